// File: rtl/seq_mult_w.sv
// seq_mult_w: parametrised sequential add-shift multiplier.
// One add-and-shift iteration per clock, unsigned or two's-complement per
// operation, with a start/busy/done handshake. Result is {A,B}.
module seq_mult_w #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 x_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic             last;
    logic             xn;
    logic [WIDTH-1:0] an;

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            s_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath: load on accepted start, one add/sub + shift per RUN cycle.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        s_d     = s_q;
        cnt_d   = cnt_q;

        // In signed mode the last multiplier bit carries negative weight,
        // so that partial product is subtracted instead of added.
        a_ext = s_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        m_ext = s_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
        last  = (cnt_q == LAST_CNT);
        sum   = (s_q && last) ? (a_ext - m_ext) : (a_ext + m_ext);

        if (b_q[0]) begin
            xn = sum[WIDTH];
            an = sum[WIDTH-1:0];
        end else begin
            xn = x_q;
            an = a_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    x_d     = 1'b0;
                    a_d     = '0;
                    b_d     = b_i;
                    m_d     = a_i;
                    s_d     = signed_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d   = s_q ? xn : 1'b0;
                a_d   = {xn, an[WIDTH-1:1]};
                b_d   = {an[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign product_o = {a_q, b_q};
    assign x_o       = x_q;

endmodule

// File: tb/tb_seq_mult_w.sv
// tb_seq_mult_w: self-checking bench for seq_mult_w at WIDTH 4, 8 and 16
// against an arithmetic reference model.
module tb_seq_mult_w;

    logic Clk = 1'b0;
    logic Reset;

    logic        start4, sgn4, busy4, done4, x4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;

    logic        start8, sgn8, busy8, done8, x8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        start16, sgn16, busy16, done16, x16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    seq_mult_w #(.WIDTH(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .start_i(start4), .signed_i(sgn4),
        .a_i(a4), .b_i(b4), .busy_o(busy4), .done_o(done4),
        .product_o(prod4), .x_o(x4)
    );

    seq_mult_w #(.WIDTH(8)) u_dut8 (
        .Clk(Clk), .Reset(Reset), .start_i(start8), .signed_i(sgn8),
        .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
        .product_o(prod8), .x_o(x8)
    );

    seq_mult_w #(.WIDTH(16)) u_dut16 (
        .Clk(Clk), .Reset(Reset), .start_i(start16), .signed_i(sgn16),
        .a_i(a16), .b_i(b16), .busy_o(busy16), .done_o(done16),
        .product_o(prod16), .x_o(x16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact product of two w-bit operands, reduced to 2w bits.
    function automatic logic [63:0] ref_mult(input int w, input logic sg,
                                             input logic [15:0] a, input logic [15:0] b);
        longint mask_w, mask_p, av, bv, p;
        mask_w = (longint'(1) << w) - 1;
        mask_p = (longint'(1) << (2 * w)) - 1;
        av = longint'({48'd0, a}) & mask_w;
        bv = longint'({48'd0, b}) & mask_w;
        if (sg && av[w-1]) av = av - (longint'(1) << w);
        if (sg && bv[w-1]) bv = bv - (longint'(1) << w);
        p = av * bv;
        return 64'(p & mask_p);
    endfunction

    task automatic drive(input int w, input logic st, input logic sg,
                         input logic [15:0] a, input logic [15:0] b);
        case (w)
            4:       begin start4  = st; sgn4  = sg; a4  = a[3:0]; b4  = b[3:0]; end
            8:       begin start8  = st; sgn8  = sg; a8  = a[7:0]; b8  = b[7:0]; end
            default: begin start16 = st; sgn16 = sg; a16 = a;      b16 = b;      end
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            4:       return done4;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4:       return busy4;
            8:       return busy8;
            default: return busy16;
        endcase
    endfunction

    function automatic logic [31:0] get_prod(input int w);
        case (w)
            4:       return 32'(prod4);
            8:       return 32'(prod8);
            default: return prod16;
        endcase
    endfunction

    // Called at the negedge after an accept edge; counts edges until done_o,
    // starting from lat0 edges already elapsed. Bounded.
    task automatic wait_done(input int w, input int lat0, output int lat);
        logic overlap;
        overlap = 1'b0;
        lat = lat0;
        while (!get_done(w) && lat < 64) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            if (get_busy(w) && get_done(w)) overlap = 1'b1;
        end
        check("busy_done_excl", 64'(overlap), 64'd0);
    endtask

    task automatic do_mult(input int w, input logic sg, input logic [15:0] a,
                           input logic [15:0] b, input string tag);
        int lat;
        @(negedge Clk);
        drive(w, 1'b1, sg, a, b);
        @(posedge Clk);
        @(negedge Clk);
        drive(w, 1'b0, ~sg, 16'($urandom), 16'($urandom));
        wait_done(w, 0, lat);
        check({tag, "_lat"}, 64'(lat), 64'(w));
        check(tag, 64'(get_prod(w)), ref_mult(w, sg, a, b));
    endtask

    initial begin
        int lat;
        logic [15:0] ra, rb;
        logic        rs;

        Reset = 1'b1;
        drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_prod", 64'(prod8), 64'd0);
        check("rst_x",    64'(x8),    64'd0);
        Reset = 1'b0;

        // Unsigned 0xFF * 0xFF
        do_mult(8, 1'b0, 16'h00FF, 16'h00FF, "u_ff_ff");
        check("u_ff_ff_val", 64'(prod8), 64'h0000_FE01);
        check("u_ff_ff_x",   64'(x8),    64'd0);

        // Signed directed cases
        do_mult(8, 1'b1, 16'h0007, 16'h00FD, "s_7_m3");
        check("s_7_m3_val", 64'(prod8), 64'h0000_FFEB);
        check("s_7_m3_x",   64'(x8),    64'd1);
        do_mult(8, 1'b1, 16'h0080, 16'h0080, "s_m128_m128");
        check("s_m128_m128_val", 64'(prod8), 64'h0000_4000);
        check("s_m128_m128_x",   64'(x8),    64'd0);
        do_mult(8, 1'b1, 16'h00FF, 16'h0001, "s_m1_1");
        check("s_m1_1_val", 64'(prod8), 64'h0000_FFFF);

        // Start during RUN is ignored
        @(negedge Clk);
        drive(8, 1'b1, 1'b0, 16'h00C5, 16'h003B);
        @(posedge Clk);
        @(negedge Clk);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge Clk);
        @(negedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        drive(8, 1'b1, 1'b1, 16'h0011, 16'h0022);
        @(posedge Clk);
        @(negedge Clk);
        check("ign_busy", 64'(busy8), 64'd1);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_done(8, 3, lat);
        check("ign_lat", 64'(lat), 64'd8);
        check("ign_prod", 64'(prod8), 64'(16'hC5 * 16'h3B));

        // Start held high through DONE: immediate restart, done for one cycle
        drive(8, 1'b1, 1'b1, 16'h00F6, 16'h0009);
        @(posedge Clk);
        @(negedge Clk);
        check("hold_done_1cyc", 64'(done8), 64'd0);
        check("hold_busy", 64'(busy8), 64'd1);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_done(8, 0, lat);
        check("hold_lat", 64'(lat), 64'd8);
        check("hold_prod", 64'(prod8), 64'h0000_FFA6);

        // Reset asserted mid-RUN
        @(negedge Clk);
        drive(8, 1'b1, 1'b0, 16'h00AB, 16'h00CD);
        @(posedge Clk);
        @(negedge Clk);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (4) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_done", 64'(done8), 64'd0);
        check("mid_rst_prod", 64'(prod8), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        do_mult(8, 1'b0, 16'h00AB, 16'h00CD, "post_rst");
        check("post_rst_val", 64'(prod8), 64'h0000_88EF);

        // Reset and start together: reset wins, start taken after release
        @(negedge Clk);
        Reset = 1'b1;
        drive(8, 1'b1, 1'b1, 16'h00F0, 16'h0003);
        @(posedge Clk);
        @(negedge Clk);
        check("rst_start_busy", 64'(busy8), 64'd0);
        Reset = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("rel_start_busy", 64'(busy8), 64'd1);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_done(8, 0, lat);
        check("rel_start_lat", 64'(lat), 64'd8);
        check("rel_start_prod", 64'(prod8), 64'h0000_FFD0);

        // Random operands at WIDTH 8
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom) & 16'h00FF;
            rb = 16'($urandom) & 16'h00FF;
            rs = 1'($urandom);
            do_mult(8, rs, ra, rb, "rand8");
        end

        // Exhaustive at WIDTH 4, both modes
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    do_mult(4, s[0], 16'(a), 16'(b), "exh4");
                end
            end
        end

        // Zero/identity at WIDTH 16, signed
        do_mult(16, 1'b1, 16'h0000, 16'h8000, "w16_zero");
        check("w16_zero_val", 64'(prod16), 64'h0000_0000);
        do_mult(16, 1'b1, 16'h7FFF, 16'h0001, "w16_id");
        check("w16_id_val", 64'(prod16), 64'h0000_7FFF);
        do_mult(16, 1'b1, 16'h8000, 16'hFFFF, "w16_neg");
        check("w16_neg_val", 64'(prod16), 64'h0000_8000);
        for (int i = 0; i < 10; i++) begin
            do_mult(16, 1'($urandom), 16'($urandom), 16'($urandom), "rand16");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_w.md
# seq_mult_w

Parametrised sequential add-shift multiplier; the next generation of the lab's fixed 8-bit multiplier datapath. Multiplies two `WIDTH`-bit operands, unsigned or two's-complement (selected per operation), using one add-and-shift iteration per clock. It exposes a start/busy/done handshake so a control FSM or the board top level can drive it. Sits between the synchronised switch/button logic and the hex display drivers.

## Interface
- `WIDTH`, default 8: operand width in bits; legal values are ≥ 2.
- `Clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `Reset`: input, 1 bit. Asynchronous, active-high. Clears all state immediately.
- `start_i`: input, 1 bit. Request a new multiply; sampled on `Clk`.
- `signed_i`: input, 1 bit. 1 = two's-complement operands, 0 = unsigned. Captured with `start_i`.
- `a_i`: input, `WIDTH` bits. Multiplicand M, captured with `start_i`.
- `b_i`: input, `WIDTH` bits. Multiplier, captured with `start_i`.
- `busy_o`: output, 1 bit. High while iterations are in progress.
- `done_o`: output, 1 bit. High while `product_o` holds a completed result.
- `product_o`: output, `2*WIDTH` bits. Result, formed as the concatenation {A,B}.
- `x_o`: output, 1 bit. Current X (sign/carry extension) bit, for display and debug.

## Operation
- Internal state:
  - X (1 bit), A (`WIDTH` bits), B (`WIDTH` bits), M (`WIDTH` bits), mode bit S.
  - Iteration counter of width clog2(`WIDTH`).
  - FSM with states IDLE, RUN, DONE.
- IDLE or DONE with `start_i`=1:
  - Load A=0, X=0, B=`b_i`, M=`a_i`, S=`signed_i`, counter=0.
  - Go to RUN.
- RUN, one iteration per cycle, with k = counter:
  - If B[0]=1, compute a (`WIDTH`+1)-bit sum from A and M, each extended by one bit: sign-extended when S=1, zero-extended when S=0.
  - The operation is A+M, except in signed mode on the last iteration (k=`WIDTH`-1), where it is A−M.
  - Take Xn = sum MSB and An = the low `WIDTH` bits of the sum.
  - If B[0]=0: Xn=X, An=A.
  - Shift {Xn,An,B} right by one in the same edge. The new X is Xn when S=1 and 0 when S=0. A receives {Xn,An[W-1:1]}. B receives {An[0],B[W-1:1]}.
  - Increment the counter. After iteration `WIDTH`-1, go to DONE.
- DONE:
  - Hold all registers. `product_o`={A,B} is the exact 2W-bit product: signed per S, otherwise unsigned.
  - Stay in DONE until the next `start_i`.
- `start_i` while in RUN is ignored. There is no queueing and no restart.
- `product_o` and `x_o` are always driven from the registers. Their contents are meaningful only when `done_o`=1.
- Operand inputs are don't-care except in the cycle where `start_i` is accepted.

## Timing
- Reset values: state=IDLE, `busy_o`=0, `done_o`=0, `product_o`=0, `x_o`=0, counter=0.
- Accept edge t0 (`start_i`=1 in IDLE or DONE):
  - `busy_o`=1 from t0 through edge t0+`WIDTH`.
  - `done_o`=0 over the same span.
- Edge t0+`WIDTH` completes the last iteration. From then on `done_o`=1, `busy_o`=0, and the result is valid.
- Latency: `WIDTH` cycles from the accept edge to `done_o`. Throughput: one result per `WIDTH`+1 cycles at best (back-to-back starts issued from DONE).
- Holding `start_i` high through DONE restarts immediately. `done_o` is then high for exactly one cycle.
- `busy_o` and `done_o` are never high together. Both decode directly from the state register, with no combinational path from inputs.
- Reset asserted mid-RUN aborts the operation. Outputs reach their reset values asynchronously, and no partial result is ever flagged as done.
- Reset and `start_i` high together: reset wins. The start is accepted on the first edge after `Reset` deasserts with `start_i` still high.

## Test plan
- `WIDTH`=8, unsigned, a=0xFF, b=0xFF, start pulse → `done_o` exactly 8 cycles after accept, `product_o`=0xFE01, `x_o`=0.
- `WIDTH`=8, signed:
  - 7 × −3 (a=0x07, b=0xFD) → `product_o`=0xFFEB.
  - −128 × −128 (0x80 × 0x80) → `product_o`=0x4000.
  - −1 × 1 → `product_o`=0xFFFF.
- Ignore and restart: `start_i` pulsed again at cycle 3 of RUN → ignored, result unchanged, done still at cycle 8. `start_i` then held high through DONE → new operands accepted, `done_o` high for one cycle only.
- Reset mid-operation: `Reset` asserted at cycle 4 of RUN between clock edges → `busy_o`, `done_o` and `product_o` go to 0 immediately. The next start runs a full 8 cycles with a correct result.
- `WIDTH`=4, exhaustive: all 256 operand pairs in both modes → every product matches the reference model, and latency is 4 cycles for every operation.
- Zero and identity cases at `WIDTH`=16, signed: 0 × 0x8000 → 0; 0x7FFF × 1 → 0x00007FFF; 0x8000 × 0xFFFF → 0x00008000.
